// File: rtl/dm_be_ctrl.sv
// dm_be_ctrl: data-memory controller with byte-masked stores and fixed wait-state latency.
// Store data arrives right-justified and is replicated across lanes according to be.
module dm_be_ctrl #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              busy,
    output logic              err
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-3:0] idx_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;

    logic [31:0]       mem [DEPTH];
    logic              accept;
    logic              be_legal;
    logic [31:0]       wdata_lane;
    logic              ram_we;

    assign accept = (state_q == S_IDLE) && req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    cnt_d   = '0;
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= we;
                idx_q   <= addr[ADDR_W-1:2];
                be_q    <= be;
                wdata_q <= wdata;
            end
        end
    end

    // Byte enables select both the write mask and how the right-justified data is replicated.
    always_comb begin
        be_legal   = 1'b0;
        wdata_lane = {4{wdata_q[7:0]}};
        case (be_q)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: be_legal = 1'b1;
            4'b0011, 4'b1100: begin
                be_legal   = 1'b1;
                wdata_lane = {2{wdata_q[15:0]}};
            end
            4'b1111: begin
                be_legal   = 1'b1;
                wdata_lane = wdata_q;
            end
            default: be_legal = 1'b0;
        endcase
    end

    // Reset on the completing edge must also suppress the write.
    assign ram_we = (state_q == S_DONE) && we_q && be_legal && !rst;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_lane[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if ((state_q == S_DONE) && !we_q) begin
            rdata_q <= mem[idx_q];
        end
    end

    assign rdata = rdata_q;
    assign done  = (state_q == S_DONE);
    assign busy  = (state_q != S_IDLE);
    assign err   = (state_q == S_DONE) && we_q && !be_legal;

endmodule

// File: tb/tb_dm_be_ctrl.sv
// Bench for dm_be_ctrl: three instances (WAIT_CYCLES 1, 0, 3) driven by directed steps,
// with expected completion results queued at issue and checked when done pulses.
module tb_dm_be_ctrl;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_v   [3];
    logic          req_v   [3];
    logic          we_v    [3];
    logic [AW-1:0] addr_v  [3];
    logic [3:0]    be_v    [3];
    logic [31:0]   wdata_v [3];
    logic [31:0]   rdata_v [3];
    logic          done_v  [3];
    logic          busy_v  [3];
    logic          err_v   [3];

    int          checks   = 0;
    int          failures = 0;
    int unsigned waits [3] = '{1, 0, 3};
    logic [31:0] last_rd [3];

    typedef struct {
        bit          is_load;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    dm_be_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst_v[0]), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .be(be_v[0]), .wdata(wdata_v[0]), .rdata(rdata_v[0]), .done(done_v[0]),
        .busy(busy_v[0]), .err(err_v[0])
    );

    dm_be_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst_v[1]), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .be(be_v[1]), .wdata(wdata_v[1]), .rdata(rdata_v[1]), .done(done_v[1]),
        .busy(busy_v[1]), .err(err_v[1])
    );

    dm_be_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst_v[2]), .req(req_v[2]), .we(we_v[2]), .addr(addr_v[2]),
        .be(be_v[2]), .wdata(wdata_v[2]), .rdata(rdata_v[2]), .done(done_v[2]),
        .busy(busy_v[2]), .err(err_v[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access; inputs are scrambled right after acceptance to prove they were latched.
    task automatic access(input int k, input logic w, input logic [AW-1:0] a,
                          input logic [3:0] b, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_err, input string tag);
        exp_t e;
        int   n;
        bit   seen;
        e.is_load = !w;
        e.rdata   = exp_rd;
        e.err     = exp_err;
        sb.push_back(e);
        @(negedge clk);
        req_v[k] = 1'b1; we_v[k] = w; addr_v[k] = a; be_v[k] = b; wdata_v[k] = d;
        @(posedge clk);
        @(negedge clk);
        req_v[k] = 1'b0; we_v[k] = ~w; addr_v[k] = ~a; be_v[k] = ~b; wdata_v[k] = ~d;
        n    = 1;
        seen = 1'b0;
        while (n <= 12) begin
            chk($sformatf("%s_busy", tag), busy_v[k], 1'b1);
            if (done_v[k]) begin
                seen = 1'b1;
                break;
            end
            chk($sformatf("%s_err_early", tag), err_v[k], 1'b0);
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        chk($sformatf("%s_done_seen", tag), seen, 1'b1);
        if (seen) begin
            chk($sformatf("%s_latency", tag), n, waits[k] + 1);
            chk($sformatf("%s_err", tag), err_v[k], e.err);
            @(negedge clk);
            chk($sformatf("%s_done_low", tag), done_v[k], 1'b0);
            chk($sformatf("%s_busy_low", tag), busy_v[k], 1'b0);
            chk($sformatf("%s_err_low", tag), err_v[k], 1'b0);
            if (e.is_load) last_rd[k] = e.rdata;
            chk($sformatf("%s_rdata", tag), rdata_v[k], last_rd[k]);
        end
    endtask

    // Holds req high continuously and measures spacing between done pulses.
    task automatic b2b(input int k, input string tag);
        int t_done[$];
        int t;
        int m;
        @(negedge clk);
        req_v[k] = 1'b1; we_v[k] = 1'b1; addr_v[k] = 12'h200; be_v[k] = 4'hF; wdata_v[k] = 32'h5A5A0000;
        for (t = 0; t < 40 && t_done.size() < 3; t++) begin
            @(negedge clk);
            if (done_v[k]) t_done.push_back(t);
        end
        req_v[k] = 1'b0;
        chk($sformatf("%s_count", tag), t_done.size(), 3);
        if (t_done.size() == 3) begin
            chk($sformatf("%s_first", tag), t_done[0], waits[k]);
            chk($sformatf("%s_gap1", tag), t_done[1] - t_done[0], waits[k] + 2);
            chk($sformatf("%s_gap2", tag), t_done[2] - t_done[1], waits[k] + 2);
        end
        m = 0;
        while (busy_v[k] && m < 10) begin
            @(negedge clk);
            m++;
        end
        chk($sformatf("%s_idle", tag), busy_v[k], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_v[k] = 1'b1; req_v[k] = 1'b0; we_v[k] = 1'b0; addr_v[k] = '0;
            be_v[k] = '0; wdata_v[k] = '0; last_rd[k] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst_v[k] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst%0d_rdata", k), rdata_v[k], 32'h0);
            chk($sformatf("rst%0d_done", k), done_v[k], 1'b0);
            chk($sformatf("rst%0d_busy", k), busy_v[k], 1'b0);
            chk($sformatf("rst%0d_err", k), err_v[k], 1'b0);
        end

        // WAIT_CYCLES=1
        access(0, 1'b1, 12'h010, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, "w1_st_word");
        access(0, 1'b0, 12'h010, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0, "w1_ld_word");
        access(0, 1'b1, 12'h010, 4'b0100, 32'h000000AA, 32'h0, 1'b0, "w1_st_b2");
        access(0, 1'b0, 12'h010, 4'b0000, 32'h0, 32'hDEAABEEF, 1'b0, "w1_ld_b2");
        access(0, 1'b0, 12'h013, 4'b0000, 32'h0, 32'hDEAABEEF, 1'b0, "w1_ld_lowbits");
        access(0, 1'b1, 12'h020, 4'b1111, 32'h11223344, 32'h0, 1'b0, "w1_st_init20");
        access(0, 1'b1, 12'h020, 4'b1100, 32'h0000CAFE, 32'h0, 1'b0, "w1_st_hi_half");
        access(0, 1'b0, 12'h020, 4'b0000, 32'h0, 32'hCAFE3344, 1'b0, "w1_ld_hi_half");
        access(0, 1'b1, 12'h030, 4'b1111, 32'h12345678, 32'h0, 1'b0, "w1_st_init30");
        access(0, 1'b1, 12'h030, 4'b0101, 32'hFFFFFFFF, 32'h0, 1'b1, "w1_st_be0101");
        access(0, 1'b1, 12'h030, 4'b0000, 32'hFFFFFFFF, 32'h0, 1'b1, "w1_st_be0000");
        access(0, 1'b1, 12'h030, 4'b1110, 32'hFFFFFFFF, 32'h0, 1'b1, "w1_st_be1110");
        access(0, 1'b0, 12'h030, 4'b0000, 32'h0, 32'h12345678, 1'b0, "w1_ld_illegal");
        access(0, 1'b1, 12'h034, 4'b1111, 32'h00000000, 32'h0, 1'b0, "w1_st_init34");
        access(0, 1'b1, 12'h034, 4'b0001, 32'h000000BB, 32'h0, 1'b0, "w1_st_b0");
        access(0, 1'b1, 12'h034, 4'b1000, 32'h00000011, 32'h0, 1'b0, "w1_st_b3");
        access(0, 1'b0, 12'h034, 4'b0000, 32'h0, 32'h110000BB, 1'b0, "w1_ld_b0b3");
        access(0, 1'b1, 12'h034, 4'b0011, 32'hFFFF5566, 32'h0, 1'b0, "w1_st_lo_half");
        access(0, 1'b1, 12'h034, 4'b0010, 32'h00000077, 32'h0, 1'b0, "w1_st_b1");
        access(0, 1'b0, 12'h034, 4'b0000, 32'h0, 32'h11007766, 1'b0, "w1_ld_mix");
        b2b(0, "w1_b2b");

        // WAIT_CYCLES=0
        access(1, 1'b1, 12'h050, 4'b1111, 32'hA5A5A5A5, 32'h0, 1'b0, "w0_st");
        access(1, 1'b0, 12'h050, 4'b0000, 32'h0, 32'hA5A5A5A5, 1'b0, "w0_ld");
        b2b(1, "w0_b2b");

        // WAIT_CYCLES=3
        access(2, 1'b1, 12'h100, 4'b1111, 32'h12345678, 32'h0, 1'b0, "w3_st");
        access(2, 1'b0, 12'h100, 4'b0000, 32'h0, 32'h12345678, 1'b0, "w3_ld");
        access(2, 1'b1, 12'h040, 4'b1111, 32'h00000000, 32'h0, 1'b0, "w3_st_init40");
        b2b(2, "w3_b2b");

        // Abort a store in WAIT, with req held high during the reset cycle.
        @(negedge clk);
        req_v[2] = 1'b1; we_v[2] = 1'b1; addr_v[2] = 12'h040; be_v[2] = 4'hF; wdata_v[2] = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy_wait", busy_v[2], 1'b1);
        rst_v[2] = 1'b1; addr_v[2] = 12'h080;
        @(negedge clk);
        rst_v[2] = 1'b0; req_v[2] = 1'b0;
        last_rd[2] = 32'h0;
        chk("abort_busy", busy_v[2], 1'b0);
        chk("abort_done", done_v[2], 1'b0);
        chk("abort_err", err_v[2], 1'b0);
        chk("abort_rdata", rdata_v[2], 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("abort_no_done%0d", i), done_v[2], 1'b0);
            chk($sformatf("abort_idle%0d", i), busy_v[2], 1'b0);
        end
        access(2, 1'b0, 12'h040, 4'b0000, 32'h0, 32'h00000000, 1'b0, "w3_ld_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
